// File: rtl/crc_pkg.sv
// crc_pkg: shared FSM state, FIFO entry type, default depth and byte-lane select for the CRC byte feeder
package crc_pkg;

    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, RESULT} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  nbytes;
        logic        last;
    } entry_t;

    // In MSB-first order, lane idx maps to byte 3-idx, which is ~idx on two bits.
    function automatic logic [7:0] pick_byte(input logic [31:0] data, input logic [1:0] idx, input logic msb_first);
        logic [1:0] lane;
        lane = msb_first ? ~idx : idx;
        return data[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/crc_word_fifo.sv
// crc_word_fifo: synchronous FIFO of crc_pkg entries
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write request and entry; ignored while full
//   pop               read request; ignored while empty
//   head              entry at the read pointer (valid when !empty)
//   full, empty       occupancy flags
//   level             entries currently held (0..DEPTH)
module crc_word_fifo
    import crc_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  entry_t     push_data,
    input  logic       pop,
    output entry_t     head,
    output logic       full,
    output logic       empty,
    output logic [3:0] level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = level == 4'(DEPTH);
    assign empty   = level == 4'd0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= 4'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level + 4'(do_push) - 4'(do_pop);
        end
    end

endmodule

// File: rtl/crc_byte_feeder.sv
// crc_byte_feeder: buffers host words and feeds them byte by byte to a CRC engine
//   clk, rst                          clock, synchronous active-high reset
//   wr_valid/wr_ready                 host word handshake
//   wr_data, wr_nbytes, wr_last       word, valid bytes minus one, end of message
//   byte_msb_first                    byte order, sampled when a word is loaded
//   crc_byte, crc_trigger             byte and one-cycle start pulse to the engine
//   crc_busy, crc_done_pulse          engine status and byte-complete pulse
//   data_done                         one-cycle engine re-init after the result is read
//   result_valid, result_ack          message complete / host has read the result
//   fifo_level, byte_count            buffered words, bytes fed since last data_done
module crc_byte_feeder
    import crc_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    input  logic [1:0]  wr_nbytes,
    input  logic        wr_last,
    output logic        wr_ready,
    input  logic        byte_msb_first,
    output logic [7:0]  crc_byte,
    output logic        crc_trigger,
    input  logic        crc_busy,
    input  logic        crc_done_pulse,
    output logic        data_done,
    output logic        result_valid,
    input  logic        result_ack,
    output logic [3:0]  fifo_level,
    output logic [15:0] byte_count
);

    state_t     state;
    entry_t     wr_entry;
    entry_t     head;
    entry_t     hold;
    logic [1:0] idx;
    logic       msb;
    logic       full;
    logic       empty;

    assign wr_entry = '{data: wr_data, nbytes: wr_nbytes, last: wr_last};
    assign wr_ready = !full;

    crc_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .push_data (wr_entry),
        .pop       (state == LOAD),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    // Trigger and byte are registered on the transition into ISSUE, so the
    // trigger is high exactly during ISSUE and crc_byte is held until the
    // next ISSUE. A new ISSUE is only entered from LOAD or on a done pulse,
    // which keeps triggers off a busy engine. crc_busy itself is not consulted;
    // the engine is expected to drop it together with crc_done_pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hold         <= '0;
            idx          <= 2'd0;
            msb          <= 1'b0;
            crc_byte     <= 8'h00;
            crc_trigger  <= 1'b0;
            data_done    <= 1'b0;
            result_valid <= 1'b0;
            byte_count   <= 16'd0;
        end else begin
            crc_trigger <= 1'b0;
            data_done   <= 1'b0;
            case (state)
                IDLE: state <= empty ? IDLE : LOAD;
                LOAD: begin
                    hold        <= head;
                    idx         <= 2'd0;
                    msb         <= byte_msb_first;
                    crc_byte    <= pick_byte(head.data, 2'd0, byte_msb_first);
                    crc_trigger <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: if (crc_done_pulse) begin
                    byte_count <= byte_count + 16'd1;
                    if (idx != hold.nbytes) begin
                        idx         <= idx + 2'd1;
                        crc_byte    <= pick_byte(hold.data, idx + 2'd1, msb);
                        crc_trigger <= 1'b1;
                        state       <= ISSUE;
                    end else if (hold.last) begin
                        result_valid <= 1'b1;
                        state        <= RESULT;
                    end else begin
                        state <= empty ? IDLE : LOAD;
                    end
                end
                RESULT: if (result_ack) begin
                    result_valid <= 1'b0;
                    data_done    <= 1'b1;
                    byte_count   <= 16'd0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_byte_feeder.sv
// tb_crc_byte_feeder: directed self-checking bench for crc_byte_feeder with a simple CRC engine model
module tb_crc_byte_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic [1:0]  wr_nbytes = '0;
    logic        wr_last = 1'b0;
    logic        wr_ready;
    logic        byte_msb_first = 1'b0;
    logic [7:0]  crc_byte;
    logic        crc_trigger;
    logic        crc_busy = 1'b0;
    logic        crc_done_pulse = 1'b0;
    logic        data_done;
    logic        result_valid;
    logic        result_ack = 1'b0;
    logic [3:0]  fifo_level;
    logic [15:0] byte_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] byte_log[$];
    logic [7:0] cur_byte = 8'h00;
    int         eng_lat = 2;
    int         eng_cnt = 0;
    int         dd_count = 0;
    int         viol_busy = 0;
    int         viol_stable = 0;

    crc_byte_feeder #(.FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_nbytes      (wr_nbytes),
        .wr_last        (wr_last),
        .wr_ready       (wr_ready),
        .byte_msb_first (byte_msb_first),
        .crc_byte       (crc_byte),
        .crc_trigger    (crc_trigger),
        .crc_busy       (crc_busy),
        .crc_done_pulse (crc_done_pulse),
        .data_done      (data_done),
        .result_valid   (result_valid),
        .result_ack     (result_ack),
        .fifo_level     (fifo_level),
        .byte_count     (byte_count)
    );

    always #5 clk = ~clk;

    // Engine model: busy for eng_lat cycles after each trigger, then one done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (data_done) dd_count++;
            crc_done_pulse = 1'b0;
            if (rst) begin
                crc_busy = 1'b0;
                eng_cnt  = 0;
            end else begin
                if (crc_trigger && crc_busy) viol_busy++;
                if (crc_busy && crc_byte !== cur_byte) viol_stable++;
                if (crc_trigger) begin
                    byte_log.push_back(crc_byte);
                    cur_byte = crc_byte;
                    crc_busy = 1'b1;
                    eng_cnt  = eng_lat;
                end else if (crc_busy) begin
                    if (eng_cnt <= 1) begin
                        crc_busy       = 1'b0;
                        crc_done_pulse = 1'b1;
                    end else begin
                        eng_cnt--;
                    end
                end
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic [1:0] nb, input logic l);
        wr_valid  = 1'b1;
        wr_data   = d;
        wr_nbytes = nb;
        wr_last   = l;
        @(negedge clk);
        wr_valid  = 1'b0;
    endtask

    task automatic wait_result();
        for (int i = 0; i < 500 && !result_valid; i++) @(negedge clk);
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_result: result_valid=%b required 1 within 500 cycles", result_valid);
        end
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({crc_byte, crc_trigger, data_done, result_valid} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs: byte=%h trig=%b dd=%b rv=%b required 00 0 0 0", crc_byte, crc_trigger, data_done, result_valid);
        end
        checks++;
        if (fifo_level !== 4'd0 || byte_count !== 16'd0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_levels: level=%0d count=%0d ready=%b required 0 0 1", fifo_level, byte_count, wr_ready);
        end
    endtask

    task automatic test_lsb_first();
        byte_log.delete();
        push(32'h44332211, 2'd3, 1'b1);
        wait_result();
        checks++;
        if (byte_log.size() != 4 || byte_log[0] !== 8'h11 || byte_log[1] !== 8'h22 || byte_log[2] !== 8'h33 || byte_log[3] !== 8'h44) begin
            errors++;
            $display("FAIL lsb_bytes: got %0d bytes %p required 11 22 33 44", byte_log.size(), byte_log);
        end
        checks++;
        if (byte_count !== 16'd4) begin
            errors++;
            $display("FAIL lsb_count: byte_count=%0d required 4", byte_count);
        end
    endtask

    // Runs while the previous message sits in RESULT, so nothing is popped.
    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (wr_ready !== (i < 4)) begin
                errors++;
                $display("FAIL full_ready[%0d]: wr_ready=%b required %b", i, wr_ready, i < 4);
            end
            push((i < 4) ? 32'hA1 + 32'(i) : 32'hEE, 2'd0, i >= 3);
            checks++;
            if (fifo_level !== ((i < 4) ? 4'(i + 1) : 4'd4)) begin
                errors++;
                $display("FAIL full_level[%0d]: fifo_level=%0d required %0d", i, fifo_level, (i < 4) ? i + 1 : 4);
            end
        end
    endtask

    task automatic test_ack();
        int dd0;
        dd0 = dd_count;
        byte_log.delete();
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        checks++;
        if (data_done !== 1'b1 || byte_count !== 16'd0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse: dd=%b count=%0d rv=%b required 1 0 0", data_done, byte_count, result_valid);
        end
        @(negedge clk);
        checks++;
        if (data_done !== 1'b0 || crc_trigger !== 1'b0 || fifo_level !== 4'd4) begin
            errors++;
            $display("FAIL ack_load: dd=%b trig=%b level=%0d required 0 0 4", data_done, crc_trigger, fifo_level);
        end
        @(negedge clk);
        checks++;
        if (crc_trigger !== 1'b1 || crc_byte !== 8'hA1 || fifo_level !== 4'd3) begin
            errors++;
            $display("FAIL ack_issue: trig=%b byte=%h level=%0d required 1 a1 3", crc_trigger, crc_byte, fifo_level);
        end
        wait_result();
        checks++;
        if (byte_log.size() != 4 || byte_log[0] !== 8'hA1 || byte_log[1] !== 8'hA2 || byte_log[2] !== 8'hA3 || byte_log[3] !== 8'hA4) begin
            errors++;
            $display("FAIL ack_bytes: got %0d bytes %p required a1 a2 a3 a4", byte_log.size(), byte_log);
        end
        checks++;
        if (byte_count !== 16'd4 || dd_count != dd0 + 1) begin
            errors++;
            $display("FAIL ack_counts: byte_count=%0d data_done_pulses=%0d required 4 1", byte_count, dd_count - dd0);
        end
        do_ack();
    endtask

    task automatic test_msb_first();
        byte_log.delete();
        byte_msb_first = 1'b1;
        push(32'h44332211, 2'd1, 1'b1);
        for (int i = 0; i < 100 && byte_log.size() == 0; i++) @(negedge clk);
        byte_msb_first = 1'b0;
        wait_result();
        checks++;
        if (byte_log.size() != 2 || byte_log[0] !== 8'h44 || byte_log[1] !== 8'h33) begin
            errors++;
            $display("FAIL msb_bytes: got %0d bytes %p required 44 33", byte_log.size(), byte_log);
        end
        checks++;
        if (byte_count !== 16'd2) begin
            errors++;
            $display("FAIL msb_count: byte_count=%0d required 2", byte_count);
        end
        do_ack();
    endtask

    task automatic test_open_msg();
        byte_log.delete();
        push(32'h00002211, 2'd1, 1'b0);
        repeat (30) @(negedge clk);
        checks++;
        if (result_valid !== 1'b0 || byte_count !== 16'd2 || byte_log.size() != 2) begin
            errors++;
            $display("FAIL open_pause: rv=%b count=%0d bytes=%0d required 0 2 2", result_valid, byte_count, byte_log.size());
        end
        push(32'h00000033, 2'd0, 1'b1);
        wait_result();
        checks++;
        if (byte_log.size() != 3 || byte_log[0] !== 8'h11 || byte_log[1] !== 8'h22 || byte_log[2] !== 8'h33 || byte_count !== 16'd3) begin
            errors++;
            $display("FAIL open_resume: bytes %p count=%0d required 11 22 33 and 3", byte_log, byte_count);
        end
        do_ack();
    endtask

    task automatic test_busy();
        eng_lat = 10;
        viol_busy = 0;
        viol_stable = 0;
        byte_log.delete();
        push(32'hDDCCBBAA, 2'd3, 1'b1);
        wait_result();
        checks++;
        if (viol_busy != 0 || viol_stable != 0) begin
            errors++;
            $display("FAIL busy_rules: trigger_while_busy=%0d byte_changes=%0d required 0 0", viol_busy, viol_stable);
        end
        checks++;
        if (byte_log.size() != 4 || byte_log[0] !== 8'hAA || byte_log[1] !== 8'hBB || byte_log[2] !== 8'hCC || byte_log[3] !== 8'hDD) begin
            errors++;
            $display("FAIL busy_bytes: got %p required aa bb cc dd", byte_log);
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        int dd0;
        eng_lat = 10;
        byte_log.delete();
        push(32'h11223344, 2'd3, 1'b1);
        push(32'h00000055, 2'd0, 1'b1);
        for (int i = 0; i < 100 && byte_log.size() < 2; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        dd0 = dd_count;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({crc_byte, crc_trigger, data_done, result_valid} !== 11'h000 || fifo_level !== 4'd0 || byte_count !== 16'd0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: byte=%h trig=%b dd=%b rv=%b level=%0d count=%0d ready=%b required 00 0 0 0 0 0 1",
                     crc_byte, crc_trigger, data_done, result_valid, fifo_level, byte_count, wr_ready);
        end
        rst = 1'b0;
        eng_lat = 2;
        repeat (5) @(negedge clk);
        checks++;
        if (dd_count != dd0 || byte_log.size() != 2) begin
            errors++;
            $display("FAIL mid_quiet: data_done_pulses=%0d bytes=%0d required 0 2", dd_count - dd0, byte_log.size());
        end
        byte_log.delete();
        push(32'h00000077, 2'd0, 1'b1);
        wait_result();
        checks++;
        if (byte_log.size() != 1 || byte_log[0] !== 8'h77 || byte_count !== 16'd1) begin
            errors++;
            $display("FAIL mid_after: bytes %p count=%0d required 77 and 1", byte_log, byte_count);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_full();
        test_ack();
        test_msb_first();
        test_open_msg();
        test_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
